// File: rtl/decrement_then_stop_srst_if.sv
// Purpose: load/count bundle for the decrement-then-stop counter.
//   master : the sequencer side that issues loads and the count enable
//   slave  : the counter itself
// Signals:
//   load_valid_i / load_ready_o  load handshake
//   start_val_i, end_val_i       start value and floor for the next count
//   step_i                       decrement per enabled cycle (0 acts as 1)
//   en_i                         count enable
//   count_o, busy_o, done_o      counter status
interface decrement_then_stop_srst_if #(
  parameter int Bits = 8
);
  logic            load_valid_i;
  logic            load_ready_o;
  logic [Bits-1:0] start_val_i;
  logic [Bits-1:0] end_val_i;
  logic [Bits-1:0] step_i;
  logic            en_i;
  logic [Bits-1:0] count_o;
  logic            busy_o;
  logic            done_o;

  modport master (
    output load_valid_i, start_val_i, end_val_i, step_i, en_i,
    input  load_ready_o, count_o, busy_o, done_o
  );

  modport slave (
    input  load_valid_i, start_val_i, end_val_i, step_i, en_i,
    output load_ready_o, count_o, busy_o, done_o
  );
endinterface

// File: rtl/decrement_then_stop_srst.sv
// Purpose: loadable down-counter that steps from a start value toward a floor,
//   saturates at the floor and holds there until the next load.
// Ports:
//   clk_i        clock, all logic on posedge
//   srst_i       synchronous active-high reset, overrides everything
//   assert_on_i  enables the simulation checks at the bottom of the file
//   bus          slave side of decrement_then_stop_srst_if
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | out of reset, count 0, waiting for a load
// ST_COUNT | decrementing on every cycle with en_i high
// ST_DONE  | count held at the floor, a new load may be accepted
module decrement_then_stop_srst #(
  parameter int Bits = 8
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       assert_on_i,
  decrement_then_stop_srst_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [Bits-1:0] count_q, count_d;
  logic [Bits-1:0] floor_q, floor_d;
  logic [Bits-1:0] step_q, step_d;
  logic            done_q, done_d;

  logic [Bits-1:0] step_eff;
  logic [Bits:0]   diff;
  logic            load_ready;

  assign load_ready = (state_q != ST_COUNT);

  // A zero step would stall the count forever; treat it as one.
  assign step_eff = (bus.step_i == '0) ? {{(Bits-1){1'b0}}, 1'b1} : bus.step_i;

  // One extra bit so an oversize step shows up as a borrow instead of a wrap.
  assign diff = {1'b0, count_q} - {1'b0, step_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    floor_d = floor_q;
    step_d  = step_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.load_valid_i) begin
          floor_d = bus.end_val_i;
          step_d  = step_eff;
          if (bus.start_val_i > bus.end_val_i) begin
            count_d = bus.start_val_i;
            state_d = ST_COUNT;
          end else begin
            // start <= end: there is nothing to count, finish on the floor.
            count_d = bus.end_val_i;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_COUNT: begin
        if (bus.en_i) begin
          if (diff[Bits] || (diff[Bits-1:0] <= floor_q)) begin
            count_d = floor_q;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = diff[Bits-1:0];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      floor_q <= '0;
      step_q  <= {{(Bits-1){1'b0}}, 1'b1};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      floor_q <= floor_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready_o = load_ready;
  assign bus.busy_o       = (state_q == ST_COUNT);
  assign bus.count_o      = count_q;
  assign bus.done_o       = done_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!srst_i && assert_on_i) begin
      if (load_ready && (bus.load_valid_i === 1'b1)) begin
        assert (bus.start_val_i >= bus.end_val_i)
          else $error("load accepted with start below floor");
      end
      assert (!$isunknown({bus.en_i, bus.load_valid_i}))
        else $error("unknown value on en_i or load_valid_i");
    end
  end
`endif

endmodule

// File: tb/tb_decrement_then_stop_srst.sv
module tb_decrement_then_stop_srst;

  logic clk = 1'b0;
  logic srst;
  logic assert_on;
  logic assert_on4;

  always #5 clk = ~clk;

  decrement_then_stop_srst_if #(.Bits(8)) bus8 ();
  decrement_then_stop_srst_if #(.Bits(4)) bus4 ();

  decrement_then_stop_srst #(.Bits(8)) dut8 (
    .clk_i       (clk),
    .srst_i      (srst),
    .assert_on_i (assert_on),
    .bus         (bus8)
  );

  decrement_then_stop_srst #(.Bits(4)) dut4 (
    .clk_i       (clk),
    .srst_i      (srst),
    .assert_on_i (assert_on4),
    .bus         (bus4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on each accepted load the whole expected count sequence
  // is precomputed; every enabled cycle consumes one entry.
  int unsigned m_cur;
  int unsigned m_seq[$];
  bit          m_done;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int unsigned s, e, st, v;
    if (srst) begin
      m_cur  = 0;
      m_seq.delete();
      m_done = 1'b0;
      m_valid = 1'b1;
    end else if (m_seq.size() == 0 && bus8.load_valid_i) begin
      s  = bus8.start_val_i;
      e  = bus8.end_val_i;
      st = (bus8.step_i == 0) ? 1 : bus8.step_i;
      m_seq.delete();
      if (s > e) begin
        m_cur  = s;
        m_done = 1'b0;
        v = s;
        while (v > e) begin
          v = (v >= e + st) ? v - st : e;
          m_seq.push_back(v);
        end
      end else begin
        m_cur  = e;
        m_done = 1'b1;
      end
    end else if (m_seq.size() != 0 && bus8.en_i) begin
      m_cur  = m_seq.pop_front();
      m_done = (m_seq.size() == 0);
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count", int'(bus8.count_o), int'(m_cur));
      check("model_done",  int'(bus8.done_o),  int'(m_done));
      check("model_busy",  int'(bus8.busy_o),  int'(m_seq.size() != 0));
      check("model_ready", int'(bus8.load_ready_o), int'(m_seq.size() == 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load8(input int s, input int e, input int st);
    bus8.load_valid_i = 1'b1;
    bus8.start_val_i  = 8'(s);
    bus8.end_val_i    = 8'(e);
    bus8.step_i       = 8'(st);
    assert_on         = (s >= e);
  endtask

  initial begin
    srst              = 1'b1;
    assert_on         = 1'b1;
    assert_on4        = 1'b1;
    bus8.load_valid_i = 1'b0;
    bus8.start_val_i  = '0;
    bus8.end_val_i    = '0;
    bus8.step_i       = '0;
    bus8.en_i         = 1'b1;
    bus4.load_valid_i = 1'b0;
    bus4.start_val_i  = '0;
    bus4.end_val_i    = '0;
    bus4.step_i       = '0;
    bus4.en_i         = 1'b1;

    tick(); tick();
    srst = 1'b0;
    check("rst_count", int'(bus8.count_o), 0);
    check("rst_ready", int'(bus8.load_ready_o), 1);
    check("rst_busy",  int'(bus8.busy_o), 0);
    check("rst_done",  int'(bus8.done_o), 0);

    // 10 -> 3 by 1
    load8(10, 3, 1);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t1_start", int'(bus8.count_o), 10);
    check("t1_busy0", int'(bus8.busy_o), 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t1_count", int'(bus8.count_o), 10 - i);
      check("t1_done",  int'(bus8.done_o), (i == 7) ? 1 : 0);
      check("t1_busy",  int'(bus8.busy_o), (i == 7) ? 0 : 1);
    end
    tick();
    check("t1_hold", int'(bus8.count_o), 3);
    check("t1_done_off", int'(bus8.done_o), 0);

    // 10 -> 0 by 4, saturating
    load8(10, 0, 4);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t2_start", int'(bus8.count_o), 10);
    tick(); check("t2_c6", int'(bus8.count_o), 6);
    tick(); check("t2_c2", int'(bus8.count_o), 2);
    tick(); check("t2_c0", int'(bus8.count_o), 0);
    check("t2_done", int'(bus8.done_o), 1);
    tick(); check("t2_hold", int'(bus8.count_o), 0);
    check("t2_done_once", int'(bus8.done_o), 0);

    // pause with en toggling, then a load attempt mid-count, then reset
    load8(200, 5, 1);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t3_start", int'(bus8.count_o), 200);
    bus8.en_i = 1'b1; tick(); check("t3_en1", int'(bus8.count_o), 199);
    bus8.en_i = 1'b0; tick(); check("t3_en0a", int'(bus8.count_o), 199);
    tick(); check("t3_en0b", int'(bus8.count_o), 199);
    bus8.en_i = 1'b1; tick(); check("t3_en1b", int'(bus8.count_o), 198);
    load8(50, 0, 9);
    check("t5_ready_low", int'(bus8.load_ready_o), 0);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t5_ignored", int'(bus8.count_o), 197);
    check("t5_busy", int'(bus8.busy_o), 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("t5_rst_count", int'(bus8.count_o), 0);
    check("t5_rst_done", int'(bus8.done_o), 0);
    check("t5_rst_busy", int'(bus8.busy_o), 0);
    check("t5_rst_ready", int'(bus8.load_ready_o), 1);

    // start == end, reloaded
    load8(7, 7, 1);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t4_count", int'(bus8.count_o), 7);
    check("t4_done", int'(bus8.done_o), 1);
    check("t4_ready", int'(bus8.load_ready_o), 1);
    tick();
    check("t4_done_off", int'(bus8.done_o), 0);
    load8(7, 7, 1);
    tick();
    bus8.load_valid_i = 1'b0;
    check("t4_done_again", int'(bus8.done_o), 1);

    // start below floor: lands on the floor with a done pulse
    load8(3, 9, 1);
    tick();
    bus8.load_valid_i = 1'b0;
    assert_on = 1'b1;
    check("lt_count", int'(bus8.count_o), 9);
    check("lt_done", int'(bus8.done_o), 1);

    // step 0 acts as step 1
    load8(5, 2, 0);
    tick();
    bus8.load_valid_i = 1'b0;
    tick(); check("t6_c4", int'(bus8.count_o), 4);
    tick(); check("t6_c3", int'(bus8.count_o), 3);
    tick(); check("t6_c2", int'(bus8.count_o), 2);
    check("t6_done", int'(bus8.done_o), 1);

    // 4-bit instance: 15 -> 0 by 15 without wrapping
    bus4.load_valid_i = 1'b1;
    bus4.start_val_i  = 4'd15;
    bus4.end_val_i    = 4'd0;
    bus4.step_i       = 4'd15;
    tick();
    bus4.load_valid_i = 1'b0;
    check("b4_start", int'(bus4.count_o), 15);
    tick();
    check("b4_zero", int'(bus4.count_o), 0);
    check("b4_done", int'(bus4.done_o), 1);
    tick();
    check("b4_hold", int'(bus4.count_o), 0);
    check("b4_done_off", int'(bus4.done_o), 0);

    // randomized traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      int s, e, st;
      srst = ($urandom_range(0, 199) == 0);
      e = $urandom_range(0, 255);
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(e, 255);
      st = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                        : $urandom_range(0, 7);
      load8(s, e, st);
      bus8.load_valid_i = ($urandom_range(0, 9) < 3);
      bus8.en_i         = ($urandom_range(0, 9) < 8);
      tick();
    end
    srst = 1'b0;
    bus8.load_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
